flush_sync_n: RTL

- Parametrised flush/stall synchroniser for the N-issue superscalar pipeline.
- Generates per-lane flush controls for the D, I and E pipeline registers from branch redirects resolved in issue (older lane kills younger lanes), decode-stage redirects, fetch alignment and per-lane issue stalls.
- Unlike the previous combinational generation, it registers a decode redirect that arrives while issue is stalled and fires it when the stall releases.
- It optionally holds flush_d for a programmable drain window after any redirect, to kill wrong-path fetch in multi-cycle fetch configurations.

---
 rtl/flush_sync_n.sv | 122 ++++++++++++
 1 files changed

// File: rtl/flush_sync_n.sv
// Per-lane D/I/E flush and stall synchroniser for an N-issue pipeline.
// Defers a decode redirect seen under an issue stall and can hold flush_d for a drain window.
module flush_sync_n #(
  parameter int LANES        = 4,
  parameter int DRAIN_CYCLES = 1,
  parameter int CW           = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LANES-1:0]     align_f,
  input  logic [2*LANES-1:0]   pcsrc_d,
  input  logic [LANES-1:0]     pcsrc_i,
  input  logic [LANES-1:0]     stall_i,
  input  logic                 stall_i_all,
  output logic [LANES-1:0]     flush_d,
  output logic [LANES-1:0]     flush_i,
  output logic [LANES-1:0]     flush_e,
  output logic                 redirect_pending,
  output logic                 drain_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            busy_q, busy_d;

  logic            any_i;
  logic            any_d;
  logic            fire;
  logic [LANES-1:0] older_i;

  // older_i[k]: some lane ahead of k in program order redirected in issue
  always_comb begin
    logic acc;
    acc     = 1'b0;
    older_i = '0;
    any_d   = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      older_i[k] = acc;
      acc        = acc | pcsrc_i[k];
      any_d      = any_d | pcsrc_d[2*k+1] | pcsrc_d[2*k];
    end
    any_i = acc;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_i || (any_d && !stall_i_all)) begin
          fire = 1'b1;
        end else if (any_d) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // An issue redirect is older than the held decode one and supersedes it.
        if (any_i || !stall_i_all) begin
          fire = 1'b1;
        end
      end
      DRAIN: begin
        if (any_i) begin
          fire = 1'b1;
        end else if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (fire) begin
      if (DRAIN_CYCLES > 0) begin
        state_d = DRAIN;
        cnt_d   = CW'(DRAIN_CYCLES);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    pend_d = (state_d == HOLD);
    busy_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

  assign flush_e = stall_i | older_i | {LANES{reset}};
  assign flush_i = older_i | ({LANES{stall_i_all}} & ~stall_i) | {LANES{reset}};
  assign flush_d = {LANES{fire | (state_q == DRAIN) | reset}} | align_f;

  assign redirect_pending = pend_q;
  assign drain_busy       = busy_q;

endmodule
